// File: rtl/trace_pkg.sv
// trace_pkg: shared defaults, FSM state codes and width helpers for trace_column_buffer
package trace_pkg;
  localparam int DEF_ROWS = 480;
  localparam int DEF_CHUNK_W = 16;
  localparam int DEF_NCH = 2;
  localparam int DEF_IDX_W = 10;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic int num_chunks(input int rows, input int w);
    return (rows + w - 1) / w;
  endfunction
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/trace_bank.sv
// trace_bank: one channel's ROWS-bit column map with clear, set(idx) and chunk read (TRACE_THICK_EN widens each set to idx-1..idx+1)
module trace_bank #(
  parameter int ROWS = 480,
  parameter int CHUNK_W = 16,
  parameter int IDX_W = 10,
  parameter int NUM_CHUNKS = 30,
  parameter int CK_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               set,
  input  logic [IDX_W-1:0]   idx,
  input  logic [CK_W-1:0]    chunk,
  output logic [CHUNK_W-1:0] data
);
  logic [ROWS-1:0] map;
  logic [ROWS-1:0] hit;
  logic [NUM_CHUNKS*CHUNK_W-1:0] padded;
  always_comb begin
    hit = '0;
    for (int r = 0; r < ROWS; r++) begin
`ifdef TRACE_THICK_EN
      hit[r] = set && int'(idx) >= r - 1 && int'(idx) <= r + 1;
`else
      hit[r] = set && int'(idx) == r;
`endif
    end
  end
  // a set on the clear cycle lands in the freshly cleared map
  always_ff @(posedge clk or posedge rst)
    if (rst) map <= '0;
    else if (clr || set) map <= (clr ? '0 : map) | hit;
  assign padded = (NUM_CHUNKS*CHUNK_W)'(map);
  assign data = padded[int'(chunk)*CHUNK_W +: CHUNK_W];
endmodule

// File: rtl/trace_column_buffer.sv
// trace_column_buffer: double-buffered per-channel column bitmaps, swapped on vsync and streamed as chunks (option: TRACE_THICK_EN)
module trace_column_buffer
  import trace_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int NCH = DEF_NCH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              vsync,
  input  logic                                              sample_valid,
  input  logic [clog2_min1(NCH)-1:0]                        sample_ch,
  input  logic [IDX_W-1:0]                                  sample_idx,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [CHUNK_W-1:0]                                out_data,
  output logic [clog2_min1(NCH)-1:0]                        out_ch,
  output logic [clog2_min1(num_chunks(ROWS, CHUNK_W))-1:0]  out_chunk,
  output logic                                              out_last,
  output logic                                              frame_done,
  output logic                                              overrun,
  output logic                                              drop
);
  localparam int NUM_CHUNKS = num_chunks(ROWS, CHUNK_W);
  localparam int CH_W = clog2_min1(NCH);
  localparam int CK_W = clog2_min1(NUM_CHUNKS);
  logic vs_q, wsel, swap, idx_ok, ch_ok, samp_ok, hs, at_last, chunk_end;
  logic [1:0] state;
  logic [CH_W-1:0] ch;
  logic [CK_W-1:0] chunk;
  logic [CHUNK_W-1:0] rdata [2][NCH];
  assign swap = vsync && !vs_q;
  assign idx_ok = {1'b0, sample_idx} < (IDX_W+1)'(ROWS);
  if (NCH == 2**CH_W) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = sample_ch < CH_W'(NCH);
  end
  assign samp_ok = sample_valid && idx_ok && ch_ok;
  // wsel is the write bank; the other one is frozen for streaming
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      trace_bank #(
        .ROWS(ROWS), .CHUNK_W(CHUNK_W), .IDX_W(IDX_W), .NUM_CHUNKS(NUM_CHUNKS), .CK_W(CK_W)
      ) u_bank (
        .clk(clk),
        .rst(rst),
        .clr(swap && wsel != 1'(b)),
        .set(samp_ok && sample_ch == CH_W'(c) && (wsel ^ swap) == 1'(b)),
        .idx(sample_idx),
        .chunk(chunk),
        .data(rdata[b][c])
      );
    end
  end
  assign out_valid = state == STREAM;
  assign out_data = out_valid ? rdata[~wsel][ch] : '0;
  assign out_ch = ch;
  assign out_chunk = chunk;
  assign chunk_end = chunk == CK_W'(NUM_CHUNKS - 1);
  assign at_last = ch == CH_W'(NCH - 1) && chunk_end;
  assign out_last = out_valid && at_last;
  assign hs = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vs_q <= 1'b0;
      wsel <= 1'b0;
      state <= IDLE;
      ch <= '0;
      chunk <= '0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
      drop <= 1'b0;
    end else begin
      vs_q <= vsync;
      drop <= sample_valid && !(idx_ok && ch_ok);
      frame_done <= hs && at_last;
      overrun <= swap && out_valid && !(hs && at_last);
      if (swap) begin
        wsel <= ~wsel;
        state <= STREAM;
        ch <= '0;
        chunk <= '0;
      end else if (hs) begin
        state <= at_last ? DONE : STREAM;
        chunk <= chunk_end ? '0 : chunk + 1'b1;
        ch <= at_last ? '0 : chunk_end ? ch + 1'b1 : ch;
      end
    end
endmodule

// File: tb/tb_trace_column_buffer.sv
// tb_trace_column_buffer: directed self-checking bench for trace_column_buffer (expectations follow TRACE_THICK_EN)
module tb_trace_column_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0;
  logic sample_valid = 1'b0;
  logic [0:0] sample_ch = '0;
  logic [9:0] sample_idx = '0;
  logic out_ready = 1'b0;
  logic out_valid, out_last, frame_done, overrun, drop;
  logic [15:0] out_data;
  logic [0:0] out_ch;
  logic [4:0] out_chunk;
  int checks = 0;
  int failures = 0;
  logic [15:0] got [60];
  int drained, last_cnt, last_pos, fd_cnt, order_err;
`ifdef TRACE_THICK_EN
  localparam logic [15:0] E17 = 16'h0007, E479 = 16'hC000, E5 = 16'h0070, E3 = 16'h001C;
  localparam logic [15:0] E8 = 16'h0380, E1 = 16'h0007, E0 = 16'h0003, E16C0 = 16'h8000, E16C1 = 16'h0003;
`else
  localparam logic [15:0] E17 = 16'h0002, E479 = 16'h8000, E5 = 16'h0020, E3 = 16'h0008;
  localparam logic [15:0] E8 = 16'h0100, E1 = 16'h0002, E0 = 16'h0001, E16C0 = 16'h0000, E16C1 = 16'h0001;
`endif

  trace_column_buffer dut (
    .clk(clk), .rst(rst), .vsync(vsync), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_idx(sample_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_chunk(out_chunk), .out_last(out_last), .frame_done(frame_done),
    .overrun(overrun), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int c, input int i);
    sample_valid = 1'b1;
    sample_ch = 1'(c);
    sample_idx = 10'(i);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  // consume one streamed frame with ready held high, recording chunks in arrival order
  task automatic drain();
    int n;
    n = 0; last_cnt = 0; last_pos = -1; fd_cnt = 0; order_err = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && n < 60; cyc++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (out_valid) begin
        got[n] = out_data;
        if (int'(out_ch) * 30 + int'(out_chunk) != n) order_err++;
        if (out_last) begin last_cnt++; last_pos = n; end
        n++;
      end
      tick();
    end
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      tick();
    end
    drained = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, frame_done, overrun, drop} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000", {out_valid, out_last, frame_done, overrun, drop});
    end
    checks++;
    if (out_data !== 16'h0 || out_ch !== 1'b0 || out_chunk !== 5'd0) begin
      failures++;
      $display("FAIL reset_payload got data=%h ch=%0d chunk=%0d want 0/0/0", out_data, out_ch, out_chunk);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_empty_frame();
    int nz;
    vs_pulse();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 1'b0 || out_chunk !== 5'd0) begin
      failures++;
      $display("FAIL empty_first got valid=%b ch=%0d chunk=%0d want 1/0/0", out_valid, out_ch, out_chunk);
    end
    drain();
    nz = 0;
    for (int i = 0; i < 60; i++) if (got[i] !== 16'h0) nz++;
    checks++;
    if (drained != 60 || nz != 0) begin
      failures++;
      $display("FAIL empty_data got chunks=%0d nonzero=%0d want 60/0", drained, nz);
    end
    checks++;
    if (last_cnt != 1 || last_pos != 59) begin
      failures++;
      $display("FAIL empty_last got count=%0d pos=%0d want 1/59", last_cnt, last_pos);
    end
    checks++;
    if (fd_cnt != 1 || order_err != 0) begin
      failures++;
      $display("FAIL empty_done got frame_done=%0d order_err=%0d want 1/0", fd_cnt, order_err);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_idle_after got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_frame_data();
    int bad;
    sample(0, 17);
    sample(1, 479);
    vs_pulse();
    drain();
    checks++;
    if (got[1] !== E17) begin
      failures++;
      $display("FAIL frame_ch0_chunk1 got=%h want=%h", got[1], E17);
    end
    checks++;
    if (got[59] !== E479) begin
      failures++;
      $display("FAIL frame_ch1_chunk29 got=%h want=%h", got[59], E479);
    end
    bad = 0;
    for (int i = 0; i < 60; i++) if (i != 1 && i != 59 && got[i] !== 16'h0) bad++;
    checks++;
    if (bad != 0 || drained != 60) begin
      failures++;
      $display("FAIL frame_others got nonzero=%0d chunks=%0d want 0/60", bad, drained);
    end
  endtask

  task automatic test_hold_and_swap_sample();
    int bad;
    sample(0, 5);
    vsync = 1'b1;
    sample(0, 3);
    vsync = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== E5 || out_ch !== 1'b0 || out_chunk !== 5'd0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable got unstable_cycles=%0d (data=%h chunk=%0d) want 0 (data=%h chunk=0)", bad, out_data, out_chunk, E5);
    end
    drain();
    checks++;
    if (got[0] !== E5 || drained != 60) begin
      failures++;
      $display("FAIL swap_sample_absent got chunk0=%h chunks=%0d want %h/60", got[0], drained, E5);
    end
    vs_pulse();
    drain();
    checks++;
    if (got[0] !== E3) begin
      failures++;
      $display("FAIL swap_sample_next got chunk0=%h want=%h", got[0], E3);
    end
  endtask

  task automatic test_overrun();
    sample(0, 8);
    vs_pulse();
    checks++;
    if (out_data !== E8) begin
      failures++;
      $display("FAIL overrun_old_chunk0 got=%h want=%h", out_data, E8);
    end
    sample(0, 1);
    out_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (out_chunk !== 5'd10 || out_ch !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_pre got chunk=%0d ch=%0d overrun=%b want 10/0/0", out_chunk, out_ch, overrun);
    end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b1 || out_chunk !== 5'd0 || out_ch !== 1'b0 || out_data !== E1) begin
      failures++;
      $display("FAIL overrun_restart got ovr=%b valid=%b chunk=%0d ch=%0d data=%h want 1/1/0/0/%h",
               overrun, out_valid, out_chunk, out_ch, out_data, E1);
    end
    tick();
    checks++;
    if (overrun !== 1'b0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL overrun_pulse_width got ovr=%b fd=%b want 0/0", overrun, frame_done);
    end
    drain();
    checks++;
    if (got[0] !== E1 || fd_cnt != 1) begin
      failures++;
      $display("FAIL overrun_new_frame got chunk0=%h frame_done=%0d want %h/1", got[0], fd_cnt, E1);
    end
  endtask

  task automatic test_drop();
    int nz;
    sample(0, 480);
    checks++;
    if (drop !== 1'b1) begin
      failures++;
      $display("FAIL drop_idx480 got=%b want=1", drop);
    end
    sample(1, 1023);
    checks++;
    if (drop !== 1'b1) begin
      failures++;
      $display("FAIL drop_idx1023 got=%b want=1", drop);
    end
    sample(1, 100);
    checks++;
    if (drop !== 1'b0) begin
      failures++;
      $display("FAIL drop_valid_sample got=%b want=0", drop);
    end
    vs_pulse();
    drain();
    nz = 0;
    for (int i = 0; i < 60; i++) if (i != 36 && got[i] !== 16'h0) nz++;
    checks++;
    if (nz != 0) begin
      failures++;
      $display("FAIL drop_unchanged got nonzero=%0d want 0", nz);
    end
  endtask

  task automatic test_edges();
    sample(0, 0);
    sample(1, 16);
    vs_pulse();
    drain();
    checks++;
    if (got[0] !== E0) begin
      failures++;
      $display("FAIL edge_idx0 got=%h want=%h", got[0], E0);
    end
    checks++;
    if (got[30] !== E16C0 || got[31] !== E16C1) begin
      failures++;
      $display("FAIL edge_idx16 got c0=%h c1=%h want %h/%h", got[30], got[31], E16C0, E16C1);
    end
  endtask

  task automatic test_swap_on_last();
    bit found;
    found = 1'b0;
    vs_pulse();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk);
      if (out_last) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || out_ch !== 1'b1 || out_chunk !== 5'd29) begin
      failures++;
      $display("FAIL last_reach got found=%b ch=%0d chunk=%0d want 1/1/29", found, out_ch, out_chunk);
    end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || overrun !== 1'b0 || out_valid !== 1'b1 || out_chunk !== 5'd0 || out_ch !== 1'b0) begin
      failures++;
      $display("FAIL swap_on_last got fd=%b ovr=%b valid=%b chunk=%0d ch=%0d want 1/0/1/0/0",
               frame_done, overrun, out_valid, out_chunk, out_ch);
    end
    drain();
  endtask

  task automatic test_async_reset();
    int nz;
    sample(0, 40);
    vs_pulse();
    sample(1, 200);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_chunk !== 5'd0 || {frame_done, overrun, drop} !== 3'b0) begin
      failures++;
      $display("FAIL async_reset got valid=%b chunk=%0d pulses=%b want 0/0/000",
               out_valid, out_chunk, {frame_done, overrun, drop});
    end
    tick();
    rst = 1'b0;
    tick();
    vs_pulse();
    drain();
    nz = 0;
    for (int i = 0; i < 60; i++) if (got[i] !== 16'h0) nz++;
    checks++;
    if (nz != 0 || drained != 60) begin
      failures++;
      $display("FAIL async_reset_cleared got nonzero=%0d chunks=%0d want 0/60", nz, drained);
    end
  endtask

  initial begin
    test_reset();
    test_empty_frame();
    test_frame_data();
    test_hold_and_swap_sample();
    test_overrun();
    test_drop();
    test_edges();
    test_swap_on_last();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trace_column_buffer.md
Name: trace_column_buffer

Overview:
Multi-channel, double-buffered column bitmap builder for the VGA trace display. Per frame, each channel's sample indices are accumulated as set bits in a ROWS-bit column map. On each vsync rising edge the banks swap. The frozen bank is then streamed to the pixel/line-buffer side as CHUNK_W-bit words over a valid/ready handshake. It sits between the sample capture logic and the VGA line renderer.

Parameters:
ROWS, 480, bits per channel column map (display height)
CHUNK_W, 16, output word width
NCH, 2, number of trace channels
IDX_W, 10, sample index width; must satisfy 2**IDX_W >= ROWS
NUM_CHUNKS (derived), ceil(ROWS/CHUNK_W), chunks per channel (30 at defaults)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
vsync  in  1  frame sync level, synchronous to clk; rising edge = frame boundary
sample_valid  in  1  sample strobe
sample_ch  in  $clog2(NCH) (min 1)  channel of sample
sample_idx  in  IDX_W  row index to set
out_valid  out  1  chunk available
out_ready  in  1  consumer accepts chunk
out_data  out  CHUNK_W  chunk bits; bit j = row chunk*CHUNK_W+j
out_ch  out  $clog2(NCH) (min 1)  channel of current chunk
out_chunk  out  $clog2(NUM_CHUNKS)  chunk number within channel
out_last  out  1  final chunk of frame (ch NCH-1, chunk NUM_CHUNKS-1)
frame_done  out  1  one-cycle pulse on the last handshake of a frame
overrun  out  1  one-cycle pulse when a swap interrupts an unfinished stream
drop  out  1  one-cycle pulse when a sample is ignored

Behaviour:
- Reset: both banks zero, write bank = 0, state IDLE, vsync edge register = 0, all outputs 0.
- Edge detect: swap when vsync=1 and the registered previous vsync=0. Swap happens at that clk edge.
- Swap: the write bank becomes the read bank, frozen. The other bank becomes the write bank and is cleared in the same cycle.
- Write: sample_valid with idx<ROWS and ch<NCH sets the bit in the write bank, 1-cycle latency. A repeated index is idempotent.
- Sample on the swap cycle belongs to the new frame: the new write bank = cleared map | that sample's bit.
- idx>=ROWS or ch>=NCH: bit not written; drop pulses the next cycle.
- FSM states:
  - IDLE: out_valid=0. A swap moves to STREAM with ch=0, chunk=0.
  - STREAM: out_valid=1. Payload is held stable while out_ready=0.
    - On handshake, advance chunk; after NUM_CHUNKS-1, set chunk=0 and ch+1.
    - Handshake with out_last=1 moves to DONE and pulses frame_done.
  - DONE: out_valid=0. A swap moves to STREAM.
- Latency: out_valid is high the cycle after the swap edge, carrying ch0 chunk0.
- Padding: bits of the final chunk at rows >= ROWS read as 0 (at defaults 480 is a multiple of 16, so there is no padding).
- Swap while in STREAM:
  - overrun pulses and the banks swap.
  - The stream restarts at ch0 chunk0 of the new read bank on the next cycle.
  - This is the only case where the payload changes without a handshake.
  - A handshake on that same cycle is discarded.
- Swap coincident with the out_last handshake: frame_done and the new swap both take effect, state goes to STREAM, no overrun.
- Async reset mid-frame: immediately returns to reset values; no pulses are emitted.

Optional Feature:
TRACE_THICK_EN
- Defined: each valid sample sets rows idx-1, idx and idx+1, clamped to 0..ROWS-1. Idx 0 sets rows 0 and 1; idx ROWS-1 sets rows ROWS-2 and ROWS-1. Drop rules are unchanged.
- Undefined: only row idx is set.

Decomposition:
- Package trace_pkg: function computing NUM_CHUNKS/clog2 widths, state enum (IDLE, STREAM, DONE), default constants ROWS/CHUNK_W/NCH.
- Sub-module trace_bank: one channel's ROWS-bit map with clear, set(idx) and a chunk-select read port. The top instantiates 2×NCH of these and muxes read/write by the bank select.

Test Plan:
- Reset, then a vsync edge with no samples -> 60 chunks of 0x0000; out_last only on ch1 chunk29; frame_done pulses once.
- Frame 1: ch0 idx=17 and ch1 idx=479, then vsync -> ch0 chunk1 = 0x0002, ch1 chunk29 = 0x8000, all other chunks 0.
- Hold out_ready=0 for 5 cycles on chunk0 -> out_data/out_ch/out_chunk stable; no advance until ready.
- Sample ch0 idx=3 on the exact swap cycle -> absent from the current stream; appears as 0x0008 in ch0 chunk0 of the next frame.
- vsync edge after 10 handshakes -> overrun pulse; next cycle out_chunk=0, out_ch=0 with new-bank data.
- Sample idx=480 or ch=2 -> drop pulse, bitmap unchanged. With TRACE_THICK_EN, idx=0 -> chunk0 = 0x0003; idx=16 -> chunk0 = 0x8000 and chunk1 = 0x0003.
